// File: rtl/et_pio_edge_in_pkg.sv
// Shared constants for the edge-capturing input PIO: register addresses,
// edge-selection encodings and a constant-evaluable ceil(log2) helper.
package et_pio_pkg;

   // Word addresses of the slave register map.
   typedef enum logic [1:0] {
      ADDR_DATA     = 2'd0,
      ADDR_IRQ_MASK = 2'd1,
      ADDR_RSVD     = 2'd2,
      ADDR_EDGE_CAP = 2'd3
   } reg_addr_e;

   // Encodings for the EDGE_TYPE parameter.
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   // ceil(log2(value)); returns 0 for value <= 1. Usable in localparams.
   function automatic int clog2(input int unsigned value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/et_pio_edge_in_if.sv
// Avalon-MM slave bus for the input PIO: 2-bit word address, chipselect,
// active-low write strobe, 32-bit data paths, zero wait states.
interface et_pio_edge_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/et_pio_edge_in_debounce.sv
// One input pin: two-flop synchroniser followed by a stability counter.
// The debounced level only follows the synchronised pin after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive clocks.
module et_debounce_bit
   import et_pio_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic INIT            = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_i,
   output logic level_o
);

   localparam int            CW_RAW  = clog2(DEBOUNCE_CYCLES);
   localparam int            CW      = (CW_RAW < 1) ? 1 : CW_RAW;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next-state: shift the synchroniser, count while the pin disagrees.
   // NOTE: every variable gets a default at the top of always_comb so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      sync_d  = {sync_q[0], pin_i};
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync_q[1];
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset to the idle pin level.
   // NOTE: flops use non-blocking assignments so every register samples
   // the pre-edge values regardless of statement or process order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q  <= {INIT, INIT};
         level_q <= INIT;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/et_pio_edge_in.sv
// Edge-capturing input PIO: debounced pin state, per-bit sticky edge
// capture with write-1-to-clear, maskable registered level interrupt.
module et_pio_edge_in
   import et_pio_pkg::*;
#(
   parameter int               WIDTH           = 2,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = EDGE_FALL,
   parameter logic [WIDTH-1:0] INIT_VALUE      = '1
) (
   input  logic               clk,
   input  logic               reset_n,
   et_pio_edge_in_if.slave    bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic               irq
);

   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_prev_q, level_prev_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             irq_q, irq_d;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] clr;
   logic             wr_en;
   logic             unused_writedata;

   // Only the low WIDTH bits of a write are meaningful.
   assign unused_writedata = ^bus.writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      et_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT            (INIT_VALUE[i])
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .pin_i   (in_port[i]),
         .level_o (level[i])
      );
   end

   // Edge selection against the previous debounced level.
   always_comb begin
      case (EDGE_TYPE)
         EDGE_RISE: edge_hit = level & ~level_prev_q;
         EDGE_FALL: edge_hit = ~level & level_prev_q;
         default:   edge_hit = level ^ level_prev_q;
      endcase
   end

   // Register next-state: mask write, capture set/clear, irq from old state.
   always_comb begin
      wr_en        = bus.chipselect && !bus.write_n;
      clr          = '0;
      mask_d       = mask_q;
      level_prev_d = level;
      if (wr_en && (reg_addr_e'(bus.address) == ADDR_IRQ_MASK)) begin
         mask_d = bus.writedata[WIDTH-1:0];
      end
      if (wr_en && (reg_addr_e'(bus.address) == ADDR_EDGE_CAP)) begin
         clr = bus.writedata[WIDTH-1:0];
      end
      // A fresh edge overrides a same-cycle clear of that bit.
      cap_d = edge_hit | (cap_q & ~clr);
      irq_d = |(cap_q & mask_q);
   end

   // Register state; the previous level reloads the idle value so reset
   // itself never looks like an edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_prev_q <= INIT_VALUE;
         mask_q       <= '0;
         cap_q        <= '0;
         irq_q        <= 1'b0;
      end else begin
         level_prev_q <= level_prev_d;
         mask_q       <= mask_d;
         cap_q        <= cap_d;
         irq_q        <= irq_d;
      end
   end

   // Zero-wait-state read mux; chipselect is ignored so the output is
   // always a deterministic function of address and register state.
   always_comb begin
      case (reg_addr_e'(bus.address))
         ADDR_DATA:     bus.readdata = 32'(level);
         ADDR_IRQ_MASK: bus.readdata = 32'(mask_q);
         ADDR_EDGE_CAP: bus.readdata = 32'(cap_q);
         default:       bus.readdata = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_et_pio_edge_in.sv
// Bench for et_pio_edge_in: a falling-edge and an any-edge instance share
// stimulus; a reference model predicts each cycle's read data and irq,
// the driver queues those predictions and a negedge monitor compares.
module tb_et_pio_edge_in;
   import et_pio_pkg::*;

   localparam int             W    = 2;
   localparam int             DB   = 4;
   localparam logic [W-1:0]   INIT = 2'b11;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [W-1:0]  in_port = INIT;
   logic          irq_f, irq_a;

   et_pio_edge_in_if bus_f ();
   et_pio_edge_in_if bus_a ();

   et_pio_edge_in #(
      .WIDTH (W), .DEBOUNCE_CYCLES (DB), .EDGE_TYPE (EDGE_FALL), .INIT_VALUE (INIT)
   ) u_dut_fall (
      .clk (clk), .reset_n (reset_n), .bus (bus_f.slave), .in_port (in_port), .irq (irq_f)
   );

   et_pio_edge_in #(
      .WIDTH (W), .DEBOUNCE_CYCLES (DB), .EDGE_TYPE (EDGE_ANY), .INIT_VALUE (INIT)
   ) u_dut_any (
      .clk (clk), .reset_n (reset_n), .bus (bus_a.slave), .in_port (in_port), .irq (irq_a)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [1:0]  addr;
      logic [31:0] rd_f;
      logic [31:0] rd_a;
      logic        irq_f;
      logic        irq_a;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // ---------------- reference model ----------------
   // pin_hist[0]: pin seen at the last edge, pin_hist[1]: the one before
   logic [W-1:0]  pin_hist[2];
   logic [W-1:0]  m_d, m_d_prev, m_mask, m_cap_f, m_cap_a;
   logic          m_irq_f, m_irq_a;
   logic [DB-1:0] m_win[W];
   int            m_seen[W];

   task automatic model_step(input logic rst_n, input logic [W-1:0] pins, input bit cs,
                             input bit wn, input logic [1:0] a, input logic [31:0] wd);
      logic [W-1:0] clr, s;
      bit           wr;
      if (!rst_n) begin
         pin_hist[0] = INIT;
         pin_hist[1] = INIT;
         m_d = INIT; m_d_prev = INIT;
         m_mask = '0; m_cap_f = '0; m_cap_a = '0;
         m_irq_f = 1'b0; m_irq_a = 1'b0;
         for (int b = 0; b < W; b++) begin
            m_win[b] = '0; m_seen[b] = 0;
         end
         return;
      end
      wr  = cs && !wn;
      clr = (wr && a == 2'd3) ? wd[W-1:0] : '0;
      m_irq_f = |(m_cap_f & m_mask);
      m_irq_a = |(m_cap_a & m_mask);
      m_cap_f = (m_d_prev & ~m_d) | (m_cap_f & ~clr);
      m_cap_a = (m_d_prev ^ m_d)  | (m_cap_a & ~clr);
      if (wr && a == 2'd1) m_mask = wd[W-1:0];
      m_d_prev = m_d;
      // A level is accepted once the synchronised pin has disagreed with
      // the held level on the last DB consecutive edges.
      s = pin_hist[1];
      for (int b = 0; b < W; b++) begin
         m_win[b] = {m_win[b][DB-2:0], s[b]};
         if (m_seen[b] < DB) m_seen[b]++;
         if (m_seen[b] == DB && m_win[b] == {DB{~m_d[b]}}) begin
            m_d[b]    = s[b];
            m_seen[b] = 0;
         end
      end
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = pins;
   endtask

   function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [W-1:0] cap);
      case (a)
         2'd0:    return 32'(m_d);
         2'd1:    return 32'(m_mask);
         2'd3:    return 32'(cap);
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("irq_fall", 32'(irq_f), 32'(e.irq_f));
            check("irq_any",  32'(irq_a), 32'(e.irq_a));
            if (e.is_rd) begin
               check($sformatf("rd_fall[a%0d]", e.addr), bus_f.readdata, e.rd_f);
               check($sformatf("rd_any[a%0d]",  e.addr), bus_a.readdata, e.rd_a);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic tick(input bit cs, input bit wn, input logic [1:0] a, input logic [31:0] wd);
      exp_t e;
      bus_f.chipselect = cs; bus_f.write_n = wn; bus_f.address = a; bus_f.writedata = wd;
      bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = wd;
      e.is_rd = cs && wn;
      e.addr  = a;
      e.rd_f  = exp_rd(a, m_cap_f);
      e.rd_a  = exp_rd(a, m_cap_a);
      e.irq_f = m_irq_f;
      e.irq_a = m_irq_a;
      sb.push_back(e);
      @(posedge clk);
      #1;
      model_step(reset_n, in_port, cs, wn, a, wd);
   endtask

   task automatic rd(input logic [1:0] a);
      tick(1'b1, 1'b1, a, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      tick(1'b1, 1'b0, a, d);
   endtask

   // n cycles of reads alternating DATA and EDGE_CAPTURE, or all four
   task automatic run(input int n, input bit all_addr);
      for (int i = 0; i < n; i++) begin
         if (all_addr) rd(2'(i));
         else          rd((i % 2 == 0) ? 2'd0 : 2'd3);
      end
   endtask

   initial begin : stim
      int  hold;
      int  op;
      bit  collided;
      bus_f.chipselect = 1'b0; bus_f.write_n = 1'b1; bus_f.address = '0; bus_f.writedata = '0;
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = '0; bus_a.writedata = '0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_step(1'b0, in_port, 1'b0, 1'b1, 2'd0, 32'd0);
      reset_n = 1'b1;

      // reset values
      run(8, 1'b1);

      // clean falling step on pin 0, mask still 0, then unmask
      in_port[0] = 1'b0;
      run(12, 1'b0);
      wr(2'd1, 32'h1);
      run(4, 1'b1);

      // short glitch on pin 1 is rejected, a long pulse is accepted
      in_port[1] = 1'b0;
      run(3, 1'b0);
      in_port[1] = 1'b1;
      run(10, 1'b0);
      in_port[1] = 1'b0;
      run(6, 1'b0);
      in_port[1] = 1'b1;
      run(12, 1'b0);

      // write-1-to-clear bit 0; irq drops with mask 0x1
      wr(2'd3, 32'h1);
      run(4, 1'b1);

      // clear bit 1 in the same cycle its new falling edge is seen
      in_port[1] = 1'b0;
      collided = 1'b0;
      for (int i = 0; i < 20 && !collided; i++) begin
         if (m_d_prev[1] && !m_d[1]) begin
            wr(2'd3, 32'h2);
            collided = 1'b1;
         end else begin
            rd(2'd3);
         end
      end
      run(4, 1'b1);
      in_port[1] = 1'b1;
      run(10, 1'b0);

      // reset in the middle of a debounce count
      in_port[0] = 1'b1;
      run(10, 1'b0);
      in_port[0] = 1'b0;
      run(4, 1'b0);
      reset_n = 1'b0;
      rd(2'd0);
      reset_n = 1'b1;
      run(12, 1'b1);

      // pin toggling on the any-edge instance, with a clear between
      in_port[0] = 1'b1;
      run(8, 1'b0);
      wr(2'd3, 32'h3);
      in_port[0] = 1'b0;
      run(8, 1'b0);

      // randomized traffic
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            in_port = W'($urandom);
            hold    = $urandom_range(1, 9);
         end
         hold--;
         if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         op = $urandom_range(0, 9);
         if (op < 6)      rd(2'($urandom));
         else if (op < 8) wr(2'($urandom), $urandom);
         else             tick(1'b0, 1'($urandom), 2'($urandom), $urandom);
         reset_n = 1'b1;
      end

      run(4, 1'b1);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
